fc_flatten_buf: RTL and testbench

- Frame buffer and flattener directly upstream of the FC dot-product accumulator.
- Accepts the last pooling stage's output one pixel per beat, all channels in parallel, in raster order.
- Re-emits the frame as a serial int8 stream in channel-major flatten order, index = c*H*W + y*W + x, one element per cycle, which is what the accumulator consumes.
- Single buffer: fill phase, then drain phase. No input accepted while draining.

---
 rtl/fc_flatten_buf.sv | 130 +++++++++++++
 tb/tb_fc_flatten_buf.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_flatten_buf.sv
// Frame buffer feeding the FC accumulator: raster pixels in, channel-major int8 stream out.
// Optional FC_FLATTEN_OVF_FLAG_EN adds a sticky ovf_err flag for beats dropped while draining.
module fc_flatten_buf #(
    parameter int IMG_W     = 14,
    parameter int IMG_H     = 14,
    parameter int CH        = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [CH*DATA_BITS-1:0] data_in,
    output logic                    in_ready,
    output logic                    valid_out,
    output logic [DATA_BITS-1:0]    data_out,
`ifdef FC_FLATTEN_OVF_FLAG_EN
    output logic                    last_out,
    output logic                    ovf_err
`else
    output logic                    last_out
`endif
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH - 1);

    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [PIX_W-1:0]     wr_pix_q, wr_pix_d;
    logic [PIX_W-1:0]     rd_pix_q, rd_pix_d;
    logic [CH_W-1:0]      rd_ch_q, rd_ch_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 wr_en;

    logic [DATA_BITS-1:0] mem_q [CH][NPIX];

    always_comb begin
        state_d  = state_q;
        wr_pix_d = wr_pix_q;
        rd_pix_d = rd_pix_q;
        rd_ch_d  = rd_ch_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        data_d   = data_q;
        wr_en    = 1'b0;
        if (state_q == S_FILL) begin
            if (valid_in) begin
                wr_en = 1'b1;
                if (wr_pix_q == PIX_LAST) begin
                    wr_pix_d = '0;
                    state_d  = S_DRAIN;
                end else begin
                    wr_pix_d = wr_pix_q + 1'b1;
                end
            end
        end else begin
            // The read is captured on this edge, so refilling pixel 0 next cycle is safe.
            valid_d = 1'b1;
            data_d  = mem_q[rd_ch_q][rd_pix_q];
            if (rd_pix_q == PIX_LAST) begin
                rd_pix_d = '0;
                if (rd_ch_q == CH_LAST) begin
                    rd_ch_d = '0;
                    last_d  = 1'b1;
                    state_d = S_FILL;
                end else begin
                    rd_ch_d = rd_ch_q + 1'b1;
                end
            end else begin
                rd_pix_d = rd_pix_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_FILL;
            wr_pix_q <= '0;
            rd_pix_q <= '0;
            rd_ch_q  <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_pix_q <= wr_pix_d;
            rd_pix_q <= rd_pix_d;
            rd_ch_q  <= rd_ch_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            data_q   <= data_d;
        end
    end

    // Storage is deliberately not reset; a new frame always overwrites it fully.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            for (int c = 0; c < CH; c++) begin
                mem_q[c][wr_pix_q] <= data_in[c*DATA_BITS +: DATA_BITS];
            end
        end
    end

`ifdef FC_FLATTEN_OVF_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (valid_in && state_q == S_DRAIN) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
`endif

    assign in_ready  = (state_q == S_FILL);
    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign last_out  = last_q;

endmodule

// File: tb/tb_fc_flatten_buf.sv
// Self-checking bench for fc_flatten_buf: frame table plus scoreboard of flattened output.
// Define FC_FLATTEN_OVF_FLAG_EN to also check the overflow flag.
module tb_fc_flatten_buf;

    localparam int W = 14;
    localparam int H = 14;
    localparam int CH = 16;
    localparam int DB = 8;
    localparam int NPIX = W * H;
    localparam int NOUT = CH * NPIX;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic [CH*DB-1:0] data_in = '0;
    logic in_ready, valid_out, last_out;
    logic [DB-1:0] data_out;
`ifdef FC_FLATTEN_OVF_FLAG_EN
    logic ovf_err;
    bit ovf_exp = 1'b0;
`endif

    always #5 clk = ~clk;

    fc_flatten_buf #(
        .IMG_W(W), .IMG_H(H), .CH(CH), .DATA_BITS(DB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .valid_in(valid_in),
        .data_in(data_in),
        .in_ready(in_ready),
        .valid_out(valid_out),
        .data_out(data_out),
`ifdef FC_FLATTEN_OVF_FLAG_EN
        .last_out(last_out),
        .ovf_err(ovf_err)
`else
        .last_out(last_out)
`endif
    );

    typedef struct packed {
        logic [DB-1:0] d;
        logic          l;
    } exp_t;

    typedef struct {
        int       pat;
        bit       tog;
        bit       hold;
        bit       b2b;
        logic [7:0] e0;
        logic [7:0] e195;
        logic [7:0] e196;
        logic [7:0] e2940;
        logic [7:0] elast;
    } vec_t;

    exp_t sb_q[$];
    logic [DB-1:0] cap [NOUT];
    int fpops = 0;
    int gpops = 0;
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] elem(int pat, int c, int p);
        logic [7:0] v;
        case (pat)
            0: v = 8'(p + c);
            1: v = 8'h80;
            2: v = 8'(-(c + 1));
            default: v = 8'h7F;
        endcase
        return v;
    endfunction

    // Scoreboard: every valid output pops one expected element.
    always @(negedge clk) begin
        if (valid_out) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                check("unexpected_valid_out", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("sb_data", int'(data_out), int'(e.d));
                check("sb_last", int'(last_out), int'(e.l));
            end
            if (fpops < NOUT) cap[fpops] = data_out;
            fpops++;
            gpops++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pixel(int pat, int p);
        for (int c = 0; c < CH; c++) data_in[c*DB +: DB] = elem(pat, c, p);
    endtask

    task automatic push_frame(int pat);
        exp_t e;
        for (int k = 0; k < NOUT; k++) begin
            e.d = elem(pat, k / NPIX, k % NPIX);
            e.l = (k == NOUT - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic fill(int pat, bit tog);
        for (int p = 0; p < NPIX; p++) begin
            if (tog) begin
                valid_in = 1'b0;
                tick();
            end
            valid_in = 1'b1;
            set_pixel(pat, p);
            if (p == 0 || p == NPIX - 1) check("in_ready_fill", int'(in_ready), 1);
            if (p == NPIX - 1) begin
                fpops = 0;
                push_frame(pat);
            end
            tick();
        end
    endtask

    task automatic run_frame(vec_t v);
        int lows;
        int highs;
        if (!v.b2b) begin
            valid_in = 1'b0;
            repeat (3) tick();
        end
        fill(v.pat, v.tog);
        // Now 1ns after the edge that accepted the last pixel.
        if (v.hold) begin
            valid_in = 1'b1;
            for (int c = 0; c < CH; c++) data_in[c*DB +: DB] = 8'h7F;
`ifdef FC_FLATTEN_OVF_FLAG_EN
            ovf_exp = 1'b1;
`endif
        end else begin
            valid_in = 1'b0;
        end
        check("valid_out_not_yet", int'(valid_out), 0);
        lows = (in_ready == 1'b0) ? 1 : 0;
        highs = 0;
        for (int i = 1; i <= NOUT; i++) begin
            tick();
            if (valid_out) highs++;
            if (i < NOUT && !in_ready) lows++;
            if (i == 1) check("first_valid_latency", int'(valid_out), 1);
`ifdef FC_FLATTEN_OVF_FLAG_EN
            if (i == 1) check("ovf_err_state", int'(ovf_err), int'(ovf_exp));
`endif
        end
        valid_in = 1'b0;
        check("in_ready_with_last", int'(in_ready), 1);
        check("last_out_final", int'(last_out), 1);
        check("in_ready_low_cycles", lows, NOUT);
        check("valid_out_contiguous", highs, NOUT);
        @(negedge clk);
        #1;
        check("frame_pop_count", fpops, NOUT);
        check("k0", int'(cap[0]), int'(v.e0));
        check("k195", int'(cap[195]), int'(v.e195));
        check("k196", int'(cap[196]), int'(v.e196));
        check("k2940", int'(cap[2940]), int'(v.e2940));
        check("k3135", int'(cap[NOUT-1]), int'(v.elast));
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC3, 8'h01, 8'h0F, 8'hD2};
        vecs[1] = '{0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC3, 8'h01, 8'h0F, 8'hD2};
        vecs[2] = '{0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hC3, 8'h01, 8'h0F, 8'hD2};
        vecs[3] = '{1, 1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        vecs[4] = '{2, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFE, 8'hF0, 8'hF0};

        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("rst_valid_out", int'(valid_out), 0);
        check("rst_last_out", int'(last_out), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_in_ready", int'(in_ready), 1);
`ifdef FC_FLATTEN_OVF_FLAG_EN
        check("rst_ovf_err", int'(ovf_err), 0);
`endif

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Reset part-way through the drain of a fresh frame.
        valid_in = 1'b0;
        repeat (2) tick();
        gpops = 0;
        fill(0, 1'b0);
        valid_in = 1'b0;
        begin
            int budget = 5000;
            while (gpops < 1001 && budget > 0) begin
                tick();
                budget--;
            end
            check("reset_wait_timeout", int'(budget > 0), 1);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb_q.delete();
        check("midrst_valid_out", int'(valid_out), 0);
        check("midrst_last_out", int'(last_out), 0);
        check("midrst_in_ready", int'(in_ready), 1);
`ifdef FC_FLATTEN_OVF_FLAG_EN
        ovf_exp = 1'b0;
        check("midrst_ovf_err", int'(ovf_err), 0);
`endif
        gpops = 0;
        repeat (5) tick();
        check("no_output_after_reset", gpops, 0);

        run_frame(vecs[0]);

        repeat (4) tick();
        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
